sub_shift_serial: RTL and testbench



---
 rtl/sub_shift_serial.sv | 187 ++++++++++++++++++
 tb/tb_sub_shift_serial.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sub_shift_serial.sv
// AES SubBytes + ShiftRows round stage: a latched 128-bit state is pushed LANES bytes
// per cycle through S-box lanes, each result written straight to its ShiftRows slot.

module sub_shift_serial_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) begin
        p = p ^ xx;
      end else begin
        p = p;
      end
      xx = xx[7] ? ({xx[6:0], 1'b0} ^ 8'h1b) : {xx[6:0], 1'b0};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Combinational S-box lookup
  always_comb begin
    s = affine(gf_inv(a));
  end

endmodule

module sub_shift_serial #(
  parameter int LANES    = 1,
  parameter bit SHIFT_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NSTEP = 16 / LANES;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic [127:0]   src_r;
  logic [127:0]   res_r;
  logic [127:0]   res_nxt_s;
  logic           in_ready_r;
  logic           out_valid_r;
  logic           busy_r;
  logic           accept_s;
  logic           last_s;
  logic [7:0]     lane_in_s  [LANES];
  logic [7:0]     lane_out_s [LANES];
  logic [6:0]     dbase_s    [LANES];

  assign accept_s  = in_valid & in_ready_r;
  assign last_s    = (cnt_r == CW'(NSTEP - 1));
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_state = res_r;
  assign busy      = busy_r;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [3:0] sidx_s;
    logic [3:0] didx_s;
    logic [6:0] sbase_s;
    logic [1:0] col_s;

    // Source byte i lives at bits [127-8i -: 8]; row = i[1:0], column = i[3:2]
    assign sidx_s  = 4'(32'(cnt_r) * LANES + k);
    assign sbase_s = 7'd120 - {sidx_s, 3'b000};
    // Row r rotates left by r columns, so source column c lands in column c - r
    assign col_s   = sidx_s[3:2] - sidx_s[1:0];
    assign didx_s  = SHIFT_EN ? {col_s, sidx_s[1:0]} : sidx_s;
    assign dbase_s[k]   = 7'd120 - {didx_s, 3'b000};
    assign lane_in_s[k] = src_r[sbase_s +: 8];

    sub_shift_serial_sbox u_sbox (
      .a (lane_in_s[k]),
      .s (lane_out_s[k])
    );
  end

  // Merge this cycle's substituted bytes into the result image
  always_comb begin
    res_nxt_s = res_r;
    if (state_r == RUN) begin
      for (int k = 0; k < LANES; k++) begin
        res_nxt_s[dbase_s[k] +: 8] = lane_out_s[k];
      end
    end else begin
      res_nxt_s = res_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      src_r       <= 128'h0;
      res_r       <= 128'h0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s != IDLE);
      res_r       <= res_nxt_s;
      if (accept_s) begin
        src_r <= in_state;
        cnt_r <= '0;
      end else if (state_r == RUN) begin
        src_r <= src_r;
        cnt_r <= last_s ? '0 : cnt_r + CW'(1);
      end else begin
        src_r <= src_r;
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_sub_shift_serial.sv
// Directed scoreboard bench: four configurations of sub_shift_serial driven in
// lockstep, expected states queued at accept and checked at the output handshake.

module tb_sub_shift_serial;

  localparam logic [127:0] V1     = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] V1_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] V1_SB  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ALL63  = 128'h63636363636363636363636363636363;
  localparam logic [127:0] B15    = 128'h00000000000000000000000000000001;
  localparam logic [127:0] B15_SR = 128'h6363637c636363636363636363636363;
  localparam logic [127:0] B15_SB = 128'h6363636363636363636363636363637c;
  localparam logic [127:0] B5     = 128'h00000000000100000000000000000000;
  localparam logic [127:0] B5_SR  = 128'h637c6363636363636363636363636363;
  localparam logic [127:0] B5_SB  = 128'h63636363637c63636363636363636363;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_state;
  logic         out_ready;
  logic         in_ready  [4];
  logic         out_valid [4];
  logic         busy      [4];
  logic [127:0] out_state [4];

  int checks = 0;
  int errors = 0;
  int exp_lat [4] = '{17, 17, 5, 2};

  logic [127:0] sb0 [$];
  logic [127:0] sb1 [$];
  logic [127:0] sb2 [$];
  logic [127:0] sb3 [$];

  sub_shift_serial #(.LANES(1),  .SHIFT_EN(1'b1)) u_d0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .in_state(in_state), .out_valid(out_valid[0]), .out_ready(out_ready), .out_state(out_state[0]), .busy(busy[0]));
  sub_shift_serial #(.LANES(1),  .SHIFT_EN(1'b0)) u_d1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .in_state(in_state), .out_valid(out_valid[1]), .out_ready(out_ready), .out_state(out_state[1]), .busy(busy[1]));
  sub_shift_serial #(.LANES(4),  .SHIFT_EN(1'b1)) u_d2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]), .in_state(in_state), .out_valid(out_valid[2]), .out_ready(out_ready), .out_state(out_state[2]), .busy(busy[2]));
  sub_shift_serial #(.LANES(16), .SHIFT_EN(1'b1)) u_d3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[3]), .in_state(in_state), .out_valid(out_valid[3]), .out_ready(out_ready), .out_state(out_state[3]), .busy(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_front(input int d, output logic [127:0] v, output bit ok);
    ok = 1'b1;
    v  = 128'h0;
    case (d)
      0: if (sb0.size() > 0) v = sb0[0]; else ok = 1'b0;
      1: if (sb1.size() > 0) v = sb1[0]; else ok = 1'b0;
      2: if (sb2.size() > 0) v = sb2[0]; else ok = 1'b0;
      default: if (sb3.size() > 0) v = sb3[0]; else ok = 1'b0;
    endcase
  endtask

  task automatic sb_drop(input int d);
    case (d)
      0: if (sb0.size() > 0) void'(sb0.pop_front());
      1: if (sb1.size() > 0) void'(sb1.pop_front());
      2: if (sb2.size() > 0) void'(sb2.pop_front());
      default: if (sb3.size() > 0) void'(sb3.pop_front());
    endcase
  endtask

  task automatic chk_idle_all(input string tag, input logic rdy);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_in_ready%0d", tag, d), 128'(in_ready[d]), 128'(rdy));
      chk($sformatf("%s_out_valid%0d", tag, d), 128'(out_valid[d]), 128'h0);
      chk($sformatf("%s_busy%0d", tag, d), 128'(busy[d]), 128'h0);
    end
  endtask

  // Accept one state on all DUTs, measure latency, optionally stall in DONE, then drain
  task automatic run_vec(input logic [127:0] v, input logic [127:0] e_sr,
                         input logic [127:0] e_sb, input int hold);
    int          lat [4];
    bit          seen [4];
    int          cyc;
    logic [127:0] e;
    bit          ok;
    sb0.push_back(e_sr);
    sb1.push_back(e_sb);
    sb2.push_back(e_sr);
    sb3.push_back(e_sr);
    for (int d = 0; d < 4; d++) begin
      lat[d]  = 0;
      seen[d] = 1'b0;
    end
    @(negedge clk);
    in_state = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = {4{$urandom()}};
    cyc = 0;
    while (!(seen[0] && seen[1] && seen[2] && seen[3]) && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 4; d++) begin
        if (out_valid[d] && !seen[d]) begin
          seen[d] = 1'b1;
          lat[d]  = cyc + 1;
        end
      end
    end
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("latency%0d", d), 128'(lat[d]), 128'(exp_lat[d]));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = (h >= 2 && h < 6);
      in_state = V1;
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
        sb_front(d, e, ok);
        chk($sformatf("hold%0d_state%0d", h, d), out_state[d], e);
        chk($sformatf("hold%0d_valid%0d", h, d), 128'(out_valid[d]), 128'h1);
        chk($sformatf("hold%0d_in_ready%0d", h, d), 128'(in_ready[d]), 128'h0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int d = 0; d < 4; d++) begin
      sb_front(d, e, ok);
      chk($sformatf("sb_nonempty%0d", d), 128'(ok), 128'h1);
      chk($sformatf("result%0d", d), out_state[d], e);
      sb_drop(d);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk_idle_all("after_drain", 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = 128'h0;
    out_ready = 1'b0;
    #3;
    chk_idle_all("reset", 1'b0);
    for (int d = 0; d < 4; d++) chk($sformatf("reset_state%0d", d), out_state[d], 128'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_all("post_reset", 1'b1);

    run_vec(V1,     V1_SR,  V1_SB,  0);
    run_vec(128'h0, ALL63,  ALL63,  0);
    run_vec(B15,    B15_SR, B15_SB, 0);
    run_vec(B5,     B5_SR,  B5_SB,  10);

    // Reset in the middle of a LANES=1 pass, at cnt = 7
    @(negedge clk);
    in_state = V1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk("midrun_busy0", 128'(busy[0]), 128'h1);
    chk("midrun_valid0", 128'(out_valid[0]), 128'h0);
    rst_n = 1'b0;
    #1;
    chk_idle_all("midrun_reset", 1'b0);
    for (int d = 0; d < 4; d++) chk($sformatf("midrun_state%0d", d), out_state[d], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_all("midrun_release", 1'b1);
    run_vec(V1, V1_SR, V1_SB, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
